// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and timing constants for the button debouncer
package debounce_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int DEBOUNCE_CYCLES_SIM     = 8;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        ARM_RELEASE = 2'd3
    } db_state_e;

    // The debounced level stays high while a release is still being qualified.
    function automatic logic is_level_state(input db_state_e s);
        return (s == PRESSED) || (s == ARM_RELEASE);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: 2-FF synchronizer, stable-count FSM, press pulse
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_button,
    output logic o_pulse,
    output logic o_level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             btn_sync;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;

    assign btn_sync = sync_q[1];

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], i_button};
        end
    end

    // Saturating increment: the counter can never wrap back into a false match.
    assign cnt_inc = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_sync) begin
                    state_d = ARM_PRESS;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ARM_PRESS: begin
                if (btn_sync) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                        pulse_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            PRESSED: begin
                if (!btn_sync) begin
                    state_d = ARM_RELEASE;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ARM_RELEASE: begin
                if (!btn_sync) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        level_d = is_level_state(state_d);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            level_q <= level_d;
        end
    end

    assign o_pulse = pulse_q;
    assign o_level = level_q;

endmodule

// File: rtl/button_debounce_pulse.sv
// rtl/button_debounce_pulse.sv - N independent debounced buttons with one pulse per press
module button_debounce_pulse
    import debounce_pkg::*;
#(
    parameter int N_BTN           = 3,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic [N_BTN-1:0] i_buttons,
    output logic [N_BTN-1:0] o_pulse,
    output logic [N_BTN-1:0] o_level
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_chan (
            .i_clock  (i_clock),
            .i_reset_n(i_reset_n),
            .i_button (i_buttons[g]),
            .o_pulse  (o_pulse[g]),
            .o_level  (o_level[g])
        );
    end

endmodule

// File: tb/tb_button_debounce_pulse.sv
// tb/tb_button_debounce_pulse.sv - directed self-checking bench for button_debounce_pulse
module tb_button_debounce_pulse;
    import debounce_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [2:0] btn;
    logic [2:0] pulse;
    logic [2:0] level;

    int errors = 0;
    int checks = 0;
    int pc[3];

    button_debounce_pulse #(
        .N_BTN(3),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_SIM)
    ) dut (
        .i_clock  (clk),
        .i_reset_n(rst_n),
        .i_buttons(btn),
        .o_pulse  (pulse),
        .o_level  (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 3; i++) pc[i] += int'(pulse[i]);
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 3; i++) pc[i] = 0;
    endtask

    initial begin
        rst_n = 1'b0;
        btn   = 3'b000;
        clear_counts();
        repeat (3) tick();
        chk3("reset_pulse", pulse, 3'b000);
        chk3("reset_level", level, 3'b000);
        rst_n = 1'b1;
        repeat (4) tick();
        chk3("idle_level", level, 3'b000);

        // clean press on channel 0
        clear_counts();
        btn = 3'b001;
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk3("clean_pulse", pulse, (k == 10) ? 3'b001 : 3'b000);
            chk3("clean_level", level, (k >= 10) ? 3'b001 : 3'b000);
        end
        btn = 3'b000;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk3("clean_rel_pulse", pulse, 3'b000);
            chk3("clean_rel_level", level, (k < 10) ? 3'b001 : 3'b000);
        end
        chki("clean_count", pc[0], 1);

        // bounce on channel 1
        clear_counts();
        for (int s = 0; s < 4; s++) begin
            btn = (s % 2 == 0) ? 3'b010 : 3'b000;
            for (int k = 0; k < 3; k++) begin
                tick();
                chk3("bounce_quiet", pulse | level, 3'b000);
            end
        end
        btn = 3'b010;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk3("bounce_pulse", pulse, (k == 10) ? 3'b010 : 3'b000);
            chk3("bounce_level", level, (k >= 10) ? 3'b010 : 3'b000);
        end
        btn = 3'b000;
        repeat (12) tick();
        chk3("bounce_released", level, 3'b000);
        chki("bounce_count", pc[1], 1);

        // 7-cycle glitch on channel 2
        clear_counts();
        btn = 3'b100;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk3("glitch_hi", pulse | level, 3'b000);
        end
        btn = 3'b000;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk3("glitch_lo", pulse | level, 3'b000);
        end
        chki("glitch_count", pc[2], 0);

        // simultaneous press and release of all channels
        clear_counts();
        btn = 3'b111;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk3("simul_pulse", pulse, (k == 10) ? 3'b111 : 3'b000);
            chk3("simul_level", level, (k >= 10) ? 3'b111 : 3'b000);
        end
        btn = 3'b000;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk3("simul_rel_pulse", pulse, 3'b000);
            chk3("simul_rel_level", level, (k < 10) ? 3'b111 : 3'b000);
        end
        chki("simul_count0", pc[0], 1);
        chki("simul_count2", pc[2], 1);

        // reset in the middle of a press count
        clear_counts();
        btn = 3'b001;
        repeat (5) tick();
        chk3("midcount_level", level, 3'b000);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk3("inreset_out", pulse | level, 3'b000);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk3("postreset_pulse", pulse, (k == 10) ? 3'b001 : 3'b000);
            chk3("postreset_level", level, (k >= 10) ? 3'b001 : 3'b000);
        end
        chki("postreset_count", pc[0], 1);
        btn = 3'b000;
        repeat (12) tick();
        chk3("postreset_released", level, 3'b000);

        // repeated press on channel 0
        clear_counts();
        btn = 3'b001;
        repeat (15) tick();
        btn = 3'b000;
        repeat (15) tick();
        btn = 3'b001;
        repeat (15) tick();
        btn = 3'b000;
        repeat (12) tick();
        chki("repeat_count", pc[0], 2);
        chki("repeat_other", pc[1] + pc[2], 0);
        chk3("repeat_level", level, 3'b000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
